// File: rtl/seg_display_scan_if.sv
// Front-panel bus between the calculator core and the 7-segment scan driver.
// The core drives value/mode/error/dp; the driver returns digit select, segments and busy.
interface seg_display_scan_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic [WIDTH-1:0]  value;
    logic              show_in_hex;
    logic              error;
    logic [DIGITS-1:0] dp_mask;
    logic [DIGITS-1:0] control;
    logic [7:0]        leds;
    logic              busy;

    modport master (
        output value, show_in_hex, error, dp_mask,
        input  control, leds, busy
    );

    modport slave (
        input  value, show_in_hex, error, dp_mask,
        output control, leds, busy
    );
endinterface

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode 7-segment driver: sequential double-dabble into a shadow frame,
// committed atomically, then scanned one digit at a time with an all-off gap between digits.
module seg_display_scan #(
    parameter int WIDTH        = 32,
    parameter int DIGITS       = 8,
    parameter int REFRESH_BITS = 13
) (
    input  logic              clock,
    input  logic              reset_n,
    seg_display_scan_if.slave bus
);

    // Enough BCD nibbles for any WIDTH-bit magnitude, so overflow is detected rather than lost.
    localparam int BCD_N = (WIDTH * 30103) / 100000 + 1;
    localparam int HEX_N = (WIDTH + 3) / 4;
    localparam int SRC_A = (BCD_N > HEX_N) ? BCD_N : HEX_N;
    localparam int SRC_N = (SRC_A > DIGITS) ? SRC_A : DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [6:0] G_BLANK = 7'h00;
    localparam logic [6:0] G_MINUS = 7'h40;
    localparam logic [6:0] G_E     = 7'h79;
    localparam logic [6:0] G_F     = 7'h71;
    localparam logic [6:0] G_R     = 7'h50;
    localparam logic [6:0] G_O_LC  = 7'h5C;
    localparam logic [6:0] G_O_UC  = 7'h3F;

    // state  | meaning
    // IDLE   | frame up to date, watching for a new (value, mode) pair
    // LOAD   | capture sign, magnitude and mode
    // SHIFT  | WIDTH double-dabble iterations (hex just waits them out)
    // COMMIT | copy converted digits into the shown frame
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} state_t;

    state_t                    state_q;
    logic                      busy_q;
    logic                      sign_q;
    logic                      hex_q;
    logic [WIDTH-1:0]          bin_q;
    logic [4*BCD_N-1:0]        bcd_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [WIDTH-1:0]          ld_val_q;
    logic [WIDTH-1:0]          last_val_q;
    logic                      last_hex_q;
    logic [DIGITS-1:0][6:0]    frame_q;
    logic                      shown_valid_q;

    logic [REFRESH_BITS-1:0]   refresh_q;
    logic [IDX_W-1:0]          scan_idx_q;
    logic [DIGITS-1:0]         control_q;
    logic [7:0]                leds_q;

    logic [4*BCD_N-1:0]        adj_d;
    logic [4*BCD_N+WIDTH-1:0]  shifted_d;
    logic [4*BCD_N-1:0]        bcd_d;
    logic [WIDTH-1:0]          bin_d;
    logic [4*SRC_N-1:0]        src_d;
    logic [DIGITS-1:0][6:0]    frame_d;
    logic                      ovf_d;
    int                        usable_d;
    int                        msd_d;
    logic [6:0]                seg_d;
    logic                      dp_d;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted_d = {adj_d, bin_q} << 1;
    end

    assign bcd_d = shifted_d[4*BCD_N+WIDTH-1:WIDTH];
    assign bin_d = shifted_d[WIDTH-1:0];

    // Build the frame to commit: overflow replaces the number with "OF"/"-OF".
    always_comb begin
        src_d = '0;
        if (hex_q) src_d[WIDTH-1:0] = bin_q;
        else       src_d[4*BCD_N-1:0] = bcd_q;
        usable_d = sign_q ? DIGITS - 1 : DIGITS;
        ovf_d = 1'b0;
        for (int i = 0; i < SRC_N; i++) begin
            if (i >= usable_d && src_d[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end
        msd_d = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (src_d[4*i +: 4] != 4'd0) msd_d = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            frame_d[i] = G_BLANK;
            if (ovf_d) begin
                if (i == 0)                frame_d[i] = G_F;
                else if (i == 1)           frame_d[i] = G_O_UC;
                else if (i == 2 && sign_q) frame_d[i] = G_MINUS;
            end else if (i <= msd_d) begin
                frame_d[i] = hex_glyph(src_d[4*i +: 4]);
            end else if (sign_q && i == msd_d + 1) begin
                frame_d[i] = G_MINUS;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            sign_q        <= 1'b0;
            hex_q         <= 1'b0;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ld_val_q      <= '0;
            last_val_q    <= '0;
            last_hex_q    <= 1'b0;
            frame_q       <= '0;
            shown_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!shown_valid_q || bus.value != last_val_q ||
                        bus.show_in_hex != last_hex_q) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    sign_q   <= bus.value[WIDTH-1];
                    bin_q    <= bus.value[WIDTH-1] ? -bus.value : bus.value;
                    hex_q    <= bus.show_in_hex;
                    ld_val_q <= bus.value;
                    bcd_q    <= '0;
                    cnt_q    <= CNT_W'(WIDTH);
                    state_q  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!hex_q) begin
                        bcd_q <= bcd_d;
                        bin_q <= bin_d;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= ST_COMMIT;
                end
                default: begin
                    frame_q       <= frame_d;
                    shown_valid_q <= 1'b1;
                    last_val_q    <= ld_val_q;
                    last_hex_q    <= hex_q;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    // Error is taken live so it appears on the very next scan slot, even mid-conversion.
    always_comb begin
        seg_d = G_BLANK;
        dp_d  = 1'b0;
        if (bus.error) begin
            dp_d = bus.dp_mask[scan_idx_q];
            case (scan_idx_q)
                IDX_W'(4): seg_d = G_E;
                IDX_W'(3): seg_d = G_R;
                IDX_W'(2): seg_d = G_R;
                IDX_W'(1): seg_d = G_O_LC;
                IDX_W'(0): seg_d = G_R;
                default:   seg_d = G_BLANK;
            endcase
        end else if (shown_valid_q) begin
            seg_d = frame_q[scan_idx_q];
            dp_d  = bus.dp_mask[scan_idx_q];
        end
    end

    // Refresh timer counts down; reaching zero ends the slot and forces one all-off clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q  <= '0;
            scan_idx_q <= '0;
            control_q  <= '1;
            leds_q     <= 8'hFF;
        end else begin
            refresh_q <= refresh_q - REFRESH_BITS'(1);
            if (refresh_q == '0) begin
                scan_idx_q <= (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
                control_q  <= '1;
                leds_q     <= 8'hFF;
            end else begin
                control_q <= ~(DIGITS'(1) << scan_idx_q);
                leds_q    <= ~{dp_d, seg_d};
            end
        end
    end

    assign bus.control = control_q;
    assign bus.leds    = leds_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: frame vectors, conversion latency, scan gap,
// live error override, rapid value changes and mid-scan reset.
module tb_seg_display_scan;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seg_display_scan_if #(.WIDTH(32), .DIGITS(8)) bus ();

    seg_display_scan #(.WIDTH(32), .DIGITS(8), .REFRESH_BITS(4)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Records the value present on the clock edge where the converter sits in LOAD.
    logic        busy_prev = 1'b0;
    logic [31:0] cap_val = '0;
    always @(posedge clock) begin
        busy_prev <= bus.busy;
        if (bus.busy && !busy_prev) cap_val <= bus.value;
    end

    typedef struct packed {
        logic [31:0] val;
        logic        hex;
        logic [7:0]  dp;
        logic [63:0] exp;   // slot7..slot0 leds
    } vec_t;

    vec_t vecs[14];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        int n = 0;
        while (bus.busy !== lvl && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(name, {63'b0, bus.busy}, {63'b0, lvl});
    endtask

    task automatic busy_len(output int m, output int bad);
        m = 0;
        bad = 0;
        while (bus.busy === 1'b1 && m < 100) begin
            if (bus.leds !== 8'hFF) bad++;
            @(negedge clock);
            m++;
        end
    endtask

    task automatic read_frame(output logic [63:0] fr);
        fr = '0;
        for (int k = 0; k < 8; k++) begin
            int n = 0;
            logic [7:0] want;
            want = ~(8'h01 << k);
            while (bus.control !== want && n < 300) begin
                @(negedge clock);
                n++;
            end
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL scan_timeout: slot %0d never selected, control %0h", k, bus.control);
            end
            fr[8*k +: 8] = bus.leds;
        end
    endtask

    initial begin
        logic [63:0] fr;
        int m, bad;

        vecs[0]  = '{32'd1234,       1'b0, 8'h00, 64'hFFFF_FFFF_F9A4_B099};
        vecs[1]  = '{32'hFFFF_FF01,  1'b1, 8'h00, 64'hFFFF_FFFF_FFBF_8E8E};
        vecs[2]  = '{32'h8000_0000,  1'b1, 8'h00, 64'hFFFF_FFFF_FFBF_C08E};
        vecs[3]  = '{32'd99999999,   1'b0, 8'h00, 64'h9090_9090_9090_9090};
        vecs[4]  = '{32'd100000000,  1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_C08E};
        vecs[5]  = '{32'd0,          1'b0, 8'h81, 64'h7FFF_FFFF_FFFF_FF40};
        vecs[6]  = '{32'hFFFF_FFFF,  1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_BFF9};
        vecs[7]  = '{32'hFF67_6981,  1'b0, 8'h00, 64'hBF90_9090_9090_9090};
        vecs[8]  = '{32'hFF67_6980,  1'b0, 8'h00, 64'hFFFF_FFFF_FFBF_C08E};
        vecs[9]  = '{32'h7FFF_FFFF,  1'b1, 8'h00, 64'hF88E_8E8E_8E8E_8E8E};
        vecs[10] = '{32'h0000_C0DE,  1'b1, 8'h00, 64'hFFFF_FFFF_C6C0_A186};
        vecs[11] = '{32'd1000,       1'b0, 8'h10, 64'hFFFF_FF7F_F9C0_C0C0};
        vecs[12] = '{32'h8000_0000,  1'b0, 8'h00, 64'hFFFF_FFFF_FFBF_C08E};
        vecs[13] = '{32'd255,        1'b1, 8'h01, 64'hFFFF_FFFF_FFFF_8E0E};

        bus.value = '0;
        bus.show_in_hex = 1'b0;
        bus.error = 1'b0;
        bus.dp_mask = '0;
        tick(3);
        check("rst_control", {56'b0, bus.control}, 64'hFF);
        check("rst_leds", {56'b0, bus.leds}, 64'hFF);
        check("rst_busy", {63'b0, bus.busy}, 64'h0);

        reset_n = 1'b1;
        wait_busy(1'b1, 5, "boot_busy_rise");
        busy_len(m, bad);
        check("boot_latency", 64'(m), 64'd34);
        check("boot_blank", 64'(bad), 64'd0);

        for (int i = 0; i < 14; i++) begin
            bus.value = vecs[i].val;
            bus.show_in_hex = vecs[i].hex;
            bus.dp_mask = vecs[i].dp;
            wait_busy(1'b1, 5, $sformatf("vec%0d_busy_rise", i));
            busy_len(m, bad);
            check($sformatf("vec%0d_latency", i), 64'(m), 64'd34);
            read_frame(fr);
            check($sformatf("vec%0d_frame", i), fr, vecs[i].exp);
        end

        // Reset in the middle of a scan: outputs blank at once, stay blank until first commit.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_control", {56'b0, bus.control}, 64'hFF);
        check("midrst_leds", {56'b0, bus.leds}, 64'hFF);
        check("midrst_busy", {63'b0, bus.busy}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_busy(1'b1, 5, "midrst_busy_rise");
        busy_len(m, bad);
        check("midrst_blank_until_commit", 64'(bad), 64'd0);
        read_frame(fr);
        check("midrst_frame", fr, vecs[13].exp);

        // All-off gap and slot length of 2**REFRESH_BITS clocks.
        m = 0;
        while (bus.control !== 8'hFF && m < 40) begin
            @(negedge clock);
            m++;
        end
        @(negedge clock);
        check("gap_onehot", 64'($countones(~bus.control)), 64'd1);
        m = 1;
        while (bus.control !== 8'hFF && m < 40) begin
            @(negedge clock);
            m++;
        end
        check("slot_period", 64'(m), 64'd16);

        // Error raised mid-conversion overrides immediately; frame appears after it drops.
        bus.value = 32'd42;
        bus.show_in_hex = 1'b0;
        bus.dp_mask = 8'h00;
        wait_busy(1'b1, 5, "err_busy_rise");
        tick(5);
        bus.error = 1'b1;
        read_frame(fr);
        check("err_frame", fr, 64'hFFFF_FF86_AFAF_A3AF);
        bus.error = 1'b0;
        wait_busy(1'b0, 60, "err_busy_fall");
        read_frame(fr);
        check("err_cleared_frame", fr, 64'hFFFF_FFFF_FFFF_99A4);

        // Value changing faster than a conversion: the final value must win, unmixed.
        for (int i = 0; i < 8; i++) begin
            bus.value = 32'(1000 + i * 111);
            tick(10);
        end
        bus.value = 32'd7;
        tick(80);
        check("stress_idle", {63'b0, bus.busy}, 64'h0);
        check("stress_captured", {32'b0, cap_val}, 64'd7);
        read_frame(fr);
        check("stress_frame", fr, 64'hFFFF_FFFF_FFFF_FFF8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
